fht_but_pipe: RTL
=================

Name: fht_but_pipe

Overview:
Pipelined, parametrised radix-2 FHT butterfly with a valid handshake and a pipeline-wide clock enable. It accepts one sample set per enabled cycle, and has selectable 1/2 output scaling, output saturation and a saturating overflow-event counter. It sits in the FHT stage datapath between the stage RAM read port and the write-back path.

Parameters:
D_BIT, 18, data width (signed, two's complement)
W_BIT, 16, twiddle width (signed Q1.(W_BIT-1); 1.0 is approximated by 2^(W_BIT-1)-1)
OUT_REG, 1, 1 adds an output register stage (latency 4); 0 gives latency 3
CNT_BIT, 16, overflow counter width

Ports:
iCLK  in  1  clock
iRESET  in  1  asynchronous active-low reset
iEN  in  1  pipeline clock enable; 0 freezes every stage register, including valid
iVALID  in  1  input sample set valid
iX_0  in  D_BIT  direct term
iX_1  in  D_BIT  term multiplied by cos
iX_2  in  D_BIT  term multiplied by sin
iSIN  in  W_BIT  twiddle sine
iCOS  in  W_BIT  twiddle cosine
iSCALE  in  1  1: outputs halved; 0: unscaled; travels with the sample through the pipeline
iCLR  in  1  synchronous clear of oOVF_CNT
oY_0  out  D_BIT  X0 + T (scaled/saturated)
oY_1  out  D_BIT  X0 - T (scaled/saturated)
oVALID  out  1  output valid
oOVF  out  1  saturation occurred on oY_0 or oY_1 for this output
oOVF_CNT  out  CNT_BIT  count of output samples with oOVF=1

Behaviour:
- Reset (iRESET=0, asynchronous): all pipeline registers, oY_0, oY_1, oVALID, oOVF and oOVF_CNT go to 0 immediately. Samples in flight are discarded. The first input accepted after reset release appears after the full latency.
- All inputs are sampled in the same cycle when iEN=1. Data, iSCALE and iVALID advance one stage per enabled cycle.
- Latency: 3 enabled cycles (OUT_REG=0) or 4 (OUT_REG=1). Throughput is 1 sample set per enabled cycle.
- Stage 1: P1=iCOS*iX_1 and P2=iSIN*iX_2, full precision (D_BIT+W_BIT bits); X0 and iSCALE delayed.
- Stage 2: S=P1+P2 (D_BIT+W_BIT+1 bits). Rounding: T=(S+2^(W_BIT-2))>>>(W_BIT-1), round-half-up. T is held in D_BIT+2 bits with no truncation.
- Stage 3: A=X0+T, B=X0-T at D_BIT+3 bits.
  - iSCALE=1: A=(A+1)>>>1, B=(B+1)>>>1.
  - Each result is then saturated to [-2^(D_BIT-1), 2^(D_BIT-1)-1].
  - oOVF=1 if either result was clipped.
- iSIN/iCOS = -2^(W_BIT-1) is legal and means exactly -1.0.
- Registers are updated only when iEN=1. With iEN=0, outputs, oVALID and oOVF hold their previous values, and samples in flight are neither lost nor duplicated.
- oY_0, oY_1 and oOVF are don't-care when oVALID=0. The datapath may update them, but oOVF_CNT counts only when oVALID=1.
- oOVF_CNT: increments by 1 in each cycle where the registered output has oVALID=1 and oOVF=1 and iEN=1 (i.e. a newly produced output).
  - Saturates at 2^CNT_BIT-1 and does not wrap.
  - iCLR=1 forces 0 and has priority over a simultaneous increment.
  - iCLR acts regardless of iEN.
- A bubble (iVALID=0) propagates as oVALID=0 after the latency. Adjacent valid samples are unaffected.

Test Plan (D_BIT=18, W_BIT=16, OUT_REG=1):
1. Basic scaled: X0=1000, X1=2000, X2=0, cos=32767, sin=0, scale=1, single valid pulse -> 4 cycles later oVALID=1 for 1 cycle, oY_0=1500, oY_1=-500, oOVF=0.
2. Saturation, unscaled: X0=131071, X1=131071, X2=0, cos=32767, sin=0, scale=0 -> T=131067, oY_0=131071 (clipped), oY_1=4, oOVF=1, oOVF_CNT=1.
3. Negative full-scale twiddle: X0=0, X1=-131072, X2=0, cos=-32768, sin=0, scale=1 -> oY_0=65536, oY_1=-65536, oOVF=0. Also run the 8 special angles (0, 45, ..., 315 deg, cos/sin = ±32767, ±23170, 0) at data extremes; every output must be within 1 LSB of the real-valued model, and oOVF must match the model clip.
4. Streaming with stall and bubble: 20 random valid sets back-to-back, iEN low for 3 cycles mid-stream, iVALID low for 1 cycle -> output order and values match the model, exactly 20 oVALID pulses, outputs frozen during the stall.
5. Reset mid-operation: drive iRESET=0 asynchronously (between clock edges) with 3 samples in flight -> outputs and oOVF_CNT are 0 at once, and no oVALID appears from the pre-reset samples after release.
6. Counter: CNT_BIT=2, 5 consecutive overflowing samples -> oOVF_CNT goes 1, 2, 3, 3, 3. Then iCLR coincident with an overflowing output -> oOVF_CNT=0.

Source files
------------

// File: rtl/fht_but_pipe.sv
// Radix-2 FHT butterfly: Y0 = X0 + (cos*X1 + sin*X2), Y1 = X0 - (...), with optional halving,
// output saturation and a saturating overflow-event counter. Every stage advances only on iEN.
module fht_but_pipe #(
    parameter int D_BIT   = 18,
    parameter int W_BIT   = 16,
    parameter int OUT_REG = 1,
    parameter int CNT_BIT = 16
) (
    input  logic                      iCLK,
    input  logic                      iRESET,
    input  logic                      iEN,
    input  logic                      iVALID,
    input  logic signed [D_BIT-1:0]   iX_0,
    input  logic signed [D_BIT-1:0]   iX_1,
    input  logic signed [D_BIT-1:0]   iX_2,
    input  logic signed [W_BIT-1:0]   iSIN,
    input  logic signed [W_BIT-1:0]   iCOS,
    input  logic                      iSCALE,
    input  logic                      iCLR,
    output logic signed [D_BIT-1:0]   oY_0,
    output logic signed [D_BIT-1:0]   oY_1,
    output logic                      oVALID,
    output logic                      oOVF,
    output logic [CNT_BIT-1:0]        oOVF_CNT
);

    localparam int PW = D_BIT + W_BIT;
    localparam int SW = PW + 1;
    localparam int TW = D_BIT + 2;
    localparam int AW = D_BIT + 3;

    localparam logic signed [SW-1:0] RND   = {{(SW-W_BIT+1){1'b0}}, 1'b1, {(W_BIT-2){1'b0}}};
    localparam logic signed [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};
    localparam logic signed [AW-1:0] Y_MAX = {{(AW-D_BIT+1){1'b0}}, {(D_BIT-1){1'b1}}};
    localparam logic signed [AW-1:0] Y_MIN = {{(AW-D_BIT+1){1'b1}}, {(D_BIT-1){1'b0}}};

    logic signed [PW-1:0]    p1_q, p2_q;
    logic signed [D_BIT-1:0] x0_s1_q;
    logic                    sc_s1_q, v_s1_q;

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            p1_q    <= '0;
            p2_q    <= '0;
            x0_s1_q <= '0;
            sc_s1_q <= 1'b0;
            v_s1_q  <= 1'b0;
        end else if (iEN) begin
            p1_q    <= iCOS * iX_1;
            p2_q    <= iSIN * iX_2;
            x0_s1_q <= iX_0;
            sc_s1_q <= iSCALE;
            v_s1_q  <= iVALID;
        end
    end

    // Sum, round-half-up and drop W_BIT-1 fraction bits; T keeps D_BIT+2 bits so cos=sin=-1.0 cannot wrap.
    logic signed [TW-1:0]    t_d, t_q;
    logic signed [D_BIT-1:0] x0_s2_q;
    logic                    sc_s2_q, v_s2_q;

    always_comb begin
        t_d = TW'(($signed({p1_q[PW-1], p1_q}) + $signed({p2_q[PW-1], p2_q}) + RND) >>> (W_BIT-1));
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            t_q     <= '0;
            x0_s2_q <= '0;
            sc_s2_q <= 1'b0;
            v_s2_q  <= 1'b0;
        end else if (iEN) begin
            t_q     <= t_d;
            x0_s2_q <= x0_s1_q;
            sc_s2_q <= sc_s1_q;
            v_s2_q  <= v_s1_q;
        end
    end

    logic signed [AW-1:0]    a_sum, b_sum, a_scl, b_scl;
    logic signed [D_BIT-1:0] y0_d, y1_d;
    logic                    ovf_d;

    always_comb begin
        a_sum = {{3{x0_s2_q[D_BIT-1]}}, x0_s2_q} + {t_q[TW-1], t_q};
        b_sum = {{3{x0_s2_q[D_BIT-1]}}, x0_s2_q} - {t_q[TW-1], t_q};
        a_scl = sc_s2_q ? ((a_sum + ONE_A) >>> 1) : a_sum;
        b_scl = sc_s2_q ? ((b_sum + ONE_A) >>> 1) : b_sum;
        y0_d  = a_scl[D_BIT-1:0];
        y1_d  = b_scl[D_BIT-1:0];
        ovf_d = 1'b0;
        if (a_scl > Y_MAX) begin
            y0_d  = Y_MAX[D_BIT-1:0];
            ovf_d = 1'b1;
        end else if (a_scl < Y_MIN) begin
            y0_d  = Y_MIN[D_BIT-1:0];
            ovf_d = 1'b1;
        end
        if (b_scl > Y_MAX) begin
            y1_d  = Y_MAX[D_BIT-1:0];
            ovf_d = 1'b1;
        end else if (b_scl < Y_MIN) begin
            y1_d  = Y_MIN[D_BIT-1:0];
            ovf_d = 1'b1;
        end
    end

    logic signed [D_BIT-1:0] y0_s3_q, y1_s3_q;
    logic                    ovf_s3_q, v_s3_q;

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            y0_s3_q  <= '0;
            y1_s3_q  <= '0;
            ovf_s3_q <= 1'b0;
            v_s3_q   <= 1'b0;
        end else if (iEN) begin
            y0_s3_q  <= y0_d;
            y1_s3_q  <= y1_d;
            ovf_s3_q <= ovf_d;
            v_s3_q   <= v_s2_q;
        end
    end

    // fin_* are the valid/overflow about to be loaded into the visible output register.
    logic fin_v, fin_ovf;

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic signed [D_BIT-1:0] y0_o_q, y1_o_q;
            logic                    ovf_o_q, v_o_q;

            always_ff @(posedge iCLK or negedge iRESET) begin
                if (!iRESET) begin
                    y0_o_q  <= '0;
                    y1_o_q  <= '0;
                    ovf_o_q <= 1'b0;
                    v_o_q   <= 1'b0;
                end else if (iEN) begin
                    y0_o_q  <= y0_s3_q;
                    y1_o_q  <= y1_s3_q;
                    ovf_o_q <= ovf_s3_q;
                    v_o_q   <= v_s3_q;
                end
            end

            assign oY_0    = y0_o_q;
            assign oY_1    = y1_o_q;
            assign oOVF    = ovf_o_q;
            assign oVALID  = v_o_q;
            assign fin_v   = v_s3_q;
            assign fin_ovf = ovf_s3_q;
        end else begin : g_noreg
            assign oY_0    = y0_s3_q;
            assign oY_1    = y1_s3_q;
            assign oOVF    = ovf_s3_q;
            assign oVALID  = v_s3_q;
            assign fin_v   = v_s2_q;
            assign fin_ovf = ovf_d;
        end
    endgenerate

    // Count steps on the same edge that makes the overflowing output visible; clear wins.
    logic [CNT_BIT-1:0] ovf_cnt_d, ovf_cnt_q;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (iCLR) begin
            ovf_cnt_d = '0;
        end else if (iEN && fin_v && fin_ovf && !(&ovf_cnt_q)) begin
            ovf_cnt_d = ovf_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign oOVF_CNT = ovf_cnt_q;

endmodule
